// File: rtl/uart_tx_fifo_sched.sv
// uart_tx_fifo_sched
//   Drains the UART TX byte FIFO into the UART transmitter over a valid/ready
//   handshake. Waits until the FIFO holds a threshold number of bytes, then
//   bursts until the FIFO is empty, with a programmable idle gap after each
//   accepted byte. Also owns the FIFO clear strobe, which is pulsed on abort.
//
//   The FIFO read port is active-low with registered read data: the byte
//   appears on fifo_data_i one cycle after fifo_n_re_o was low.
//
//   Optional feature: define UART_TX_SCHED_TIMEOUT_EN to force a drain when
//   bytes sit below the threshold for TIMEOUT_CYCLES idle cycles. Without it,
//   bytes below the threshold wait indefinitely.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for enable and enough bytes (or forced drain)
//   READ    | fifo_n_re_o low for this one cycle
//   LATCH   | FIFO read data valid; capture into tx_data_o, raise valid
//   SEND    | hold byte until the transmitter accepts it
//   GAP     | inter-byte idle countdown after an accepted byte

module uart_tx_fifo_sched #(
  parameter int CNT_W = 16
`ifdef UART_TX_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        abort_i,
  input  logic [15:0] thresh_i,
  input  logic [15:0] gap_i,
  input  logic [7:0]  fifo_data_i,
  input  logic [15:0] fifo_bytes_i,
  input  logic        fifo_empty_i,
  output logic        fifo_n_re_o,
  output logic        fifo_n_clr_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] gap_cnt_nxt;
  logic [15:0]      thresh_eff;
  logic             can_continue;
  logic             start_ok;
  logic             accept;
  logic             tmo_fire;

  // A zero threshold would otherwise let an empty FIFO look "full enough".
  assign thresh_eff   = (thresh_i == 16'd0) ? 16'd1 : thresh_i;
  // Mid-burst the threshold no longer matters, only that a byte is present.
  assign can_continue = en_i & ~fifo_empty_i;
  assign start_ok     = can_continue & (fifo_bytes_i >= thresh_eff);
  // Ready outside SEND must not count as a handshake.
  assign accept       = (state == S_SEND) & tx_valid_o & tx_ready_i;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_arm;

  // Counting only while enabled with some, but too few, bytes waiting.
  assign tmo_arm  = can_continue & (fifo_bytes_i < thresh_eff);
  assign tmo_fire = (state == S_IDLE) & tmo_arm & (tmo_cnt == TMO_LAST);

  // Idle timeout counter: saturating, cleared on abort, empty FIFO or leaving IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (abort_i || fifo_empty_i || state_nxt != S_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_arm && tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Next-state and gap counter logic; abort overrides every transition.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start_ok || tmo_fire) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          if (gap_i != 16'd0) begin
            // gap_i is sampled only here; later changes affect the next byte.
            state_nxt   = S_GAP;
            gap_cnt_nxt = CNT_W'(gap_i - 16'd1);
          end else begin
            state_nxt = can_continue ? S_READ : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = can_continue ? S_READ : S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        gap_cnt_nxt = '0;
      end
    endcase
    if (abort_i) begin
      state_nxt   = S_IDLE;
      gap_cnt_nxt = '0;
    end
  end

  // State and gap counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // FIFO strobes and busy flag are decoded from the next state so they line
  // up with the state they describe while still coming straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_n_re_o  <= 1'b1;
      fifo_n_clr_o <= 1'b1;
      busy_o       <= 1'b0;
    end else begin
      fifo_n_re_o  <= (state_nxt != S_READ);
      fifo_n_clr_o <= ~abort_i;
      busy_o       <= (state_nxt != S_IDLE);
    end
  end

  // Transmit byte register: load in LATCH, hold through SEND, drop on accept or abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
    end else if (abort_i) begin
      tx_valid_o <= 1'b0;
    end else if (state == S_LATCH) begin
      tx_data_o  <= fifo_data_i;
      tx_valid_o <= 1'b1;
    end else if (accept) begin
      tx_valid_o <= 1'b0;
    end
  end

endmodule
